// File: rtl/i2c_burst_master.sv
// Wishbone-controlled I2C burst master: register file, TX/RX byte FIFOs and a
// sequencer that walks an external byte controller through START/ADR/DATA/STOP.
module i2c_burst_master #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       wb_inta_o,
  output logic       bc_start,
  output logic       bc_stop,
  output logic       bc_read,
  output logic       bc_write,
  output logic       bc_ack_in,
  output logic [7:0] bc_din,
  input  logic       bc_cmd_ack,
  input  logic       bc_ack_out,
  input  logic [7:0] bc_dout,
  input  logic       bc_al
);
  typedef enum logic [2:0] {IDLE, ADR, DATA, STOP, DONE} state_t;

  state_t        r_state, w_nxt;
  logic          r_en, r_ien, r_al, r_nack, r_if, r_ovf, r_ack, r_inta;
  logic [7:0]    r_sadr, r_len, r_sadr_l, r_rem, r_dat, w_rdata, w_stat;

  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [AW:0]   r_tx_cnt, r_rx_cnt;

  logic w_req, w_wr, w_rd_data, w_go, w_clr, w_ovf;
  logic w_tx_push, w_tx_pop, w_tx_flush, w_tx_empty, w_tx_full;
  logic w_rx_push, w_rx_pop, w_rx_flush, w_rx_empty, w_rx_full;
  logic w_rem_dec, w_set_nack, w_set_al, w_set_if;

  assign w_req      = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_wr       = w_req & wb_we_i;
  assign w_rd_data  = w_req & ~wb_we_i & (wb_adr_i == 3'd3);
  assign w_go       = w_wr & (wb_adr_i == 3'd4) & wb_dat_i[7] & r_en & (r_state == IDLE);
  assign w_clr      = w_wr & (wb_adr_i == 3'd5) & wb_dat_i[4];
  assign w_tx_flush = w_wr & (wb_adr_i == 3'd6) & wb_dat_i[0];
  assign w_rx_flush = w_wr & (wb_adr_i == 3'd6) & wb_dat_i[1];

  // Depth is a power of two, so the count MSB alone marks a full FIFO.
  assign w_tx_full  = r_tx_cnt[AW];
  assign w_rx_full  = r_rx_cnt[AW];
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_tx_push  = w_wr & (wb_adr_i == 3'd3) & ~w_tx_full;
  assign w_rx_pop   = w_rd_data & ~w_rx_empty;
  assign w_ovf      = (w_wr & (wb_adr_i == 3'd3) & w_tx_full) | (w_rd_data & w_rx_empty);

  assign w_stat     = {(r_state != IDLE), r_al, r_nack, r_if,
                       w_tx_full, w_tx_empty, w_rx_empty, r_ovf};
  assign wb_dat_o   = r_dat;
  assign wb_ack_o   = r_ack;
  assign wb_inta_o  = r_inta;

  always_comb begin
    w_rdata = 8'h00;
    case (wb_adr_i)
      3'd0:    w_rdata = {r_en, r_ien, 6'b0};
      3'd1:    w_rdata = r_sadr;
      3'd2:    w_rdata = r_len;
      3'd3:    if (!w_rx_empty) w_rdata = r_rx_mem[r_rx_rp];
      3'd5:    w_rdata = w_stat;
      default: w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  // Commands decode straight from state, so an async reset clears them at once.
  always_comb begin
    w_nxt      = r_state;
    bc_start   = 1'b0;
    bc_stop    = 1'b0;
    bc_read    = 1'b0;
    bc_write   = 1'b0;
    bc_ack_in  = 1'b0;
    bc_din     = 8'h00;
    w_tx_pop   = 1'b0;
    w_rx_push  = 1'b0;
    w_rem_dec  = 1'b0;
    w_set_nack = 1'b0;
    w_set_al   = 1'b0;
    w_set_if   = 1'b0;
    case (r_state)
      IDLE: if (w_go) w_nxt = ADR;
      ADR: begin
        bc_start = 1'b1;
        bc_write = 1'b1;
        bc_din   = r_sadr_l;
        if (bc_cmd_ack) begin
          if (bc_ack_out) begin
            w_set_nack = 1'b1;
            w_nxt      = STOP;
          end else if (r_rem == 8'd0) w_nxt = STOP;
          else                        w_nxt = DATA;
        end
      end
      DATA: begin
        if (!r_sadr_l[0]) begin
          if (!w_tx_empty) begin
            bc_write = 1'b1;
            bc_din   = r_tx_mem[r_tx_rp];
            if (bc_cmd_ack) begin
              w_tx_pop  = 1'b1;
              w_rem_dec = 1'b1;
              if (bc_ack_out) begin
                w_set_nack = 1'b1;
                w_nxt      = STOP;
              end else if (r_rem == 8'd1) w_nxt = STOP;
            end
          end
        end else if (!w_rx_full) begin
          bc_read   = 1'b1;
          bc_ack_in = (r_rem == 8'd1);
          if (bc_cmd_ack) begin
            w_rx_push = 1'b1;
            w_rem_dec = 1'b1;
            if (r_rem == 8'd1) w_nxt = STOP;
          end
        end
      end
      STOP: begin
        bc_stop = 1'b1;
        if (bc_cmd_ack) w_nxt = DONE;
      end
      DONE: begin
        w_set_if = 1'b1;
        w_nxt    = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    // Lost arbitration abandons the bus outright: no STOP, no FIFO side effects.
    if (r_state != IDLE && bc_al) begin
      w_nxt      = IDLE;
      w_set_al   = 1'b1;
      w_set_if   = 1'b1;
      w_set_nack = 1'b0;
      w_tx_pop   = 1'b0;
      w_rx_push  = 1'b0;
      w_rem_dec  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_en <= 1'b0; r_ien <= 1'b0; r_al <= 1'b0; r_nack <= 1'b0;
      r_if <= 1'b0; r_ovf <= 1'b0; r_ack <= 1'b0; r_inta <= 1'b0;
      r_sadr <= 8'h00; r_len <= 8'h00; r_sadr_l <= 8'h00; r_rem <= 8'h00; r_dat <= 8'h00;
    end else begin
      r_ack  <= w_req;
      r_inta <= r_ien & r_if;
      if (w_req) r_dat <= w_rdata;
      if (w_wr) begin
        case (wb_adr_i)
          3'd0: begin r_en <= wb_dat_i[7]; r_ien <= wb_dat_i[6]; end
          3'd1: r_sadr <= wb_dat_i;
          3'd2: r_len  <= wb_dat_i;
          default: ;
        endcase
      end
      // The burst runs on snapshots so register writes while busy are harmless.
      if (w_go) begin
        r_sadr_l <= r_sadr;
        r_rem    <= r_len;
      end else if (w_rem_dec) r_rem <= r_rem - 8'd1;
      if (w_clr) begin r_if <= 1'b0; r_al <= 1'b0; r_nack <= 1'b0; r_ovf <= 1'b0; end
      if (w_go)  begin r_al <= 1'b0; r_nack <= 1'b0; end
      if (w_set_al)   r_al   <= 1'b1;
      if (w_set_nack) r_nack <= 1'b1;
      if (w_set_if)   r_if   <= 1'b1;
      if (w_ovf)      r_ovf  <= 1'b1;
    end
  end

  // Flush outranks any same-cycle push or pop on the same FIFO.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
    end else if (w_tx_flush) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt + {{AW{1'b0}}, w_tx_push} - {{AW{1'b0}}, w_tx_pop};
    end
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
    end else if (w_rx_flush) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      r_rx_cnt <= r_rx_cnt + {{AW{1'b0}}, w_rx_push} - {{AW{1'b0}}, w_rx_pop};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= wb_dat_i;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= bc_dout;
  end
endmodule

// File: doc/i2c_burst_master.md
I2C_BURST_MASTER -- requirements
Module: i2c_burst_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, the entries in each of the TX and RX FIFOs; it is a power of two, at least 2.
REQ-002 SHALL have parameter AW, default log2(FIFO_DEPTH), the FIFO pointer width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: wb_clk_i in 1 (clock), arst_i in 1 (async reset, active low).
REQ-004 SHALL have Wishbone ports: wb_adr_i in 3 (register address); wb_dat_i in 8 (write data); wb_dat_o out 8 (read data).
REQ-005 SHALL have Wishbone ports: wb_we_i in 1; wb_stb_i in 1; wb_cyc_i in 1; wb_ack_o out 1; wb_inta_o out 1 (interrupt).
REQ-006 SHALL have byte-controller command outputs: bc_start, bc_stop, bc_read, bc_write, bc_ack_in, each out 1; bc_din out 8 (byte to send).
REQ-007 SHALL have byte-controller inputs: bc_cmd_ack in 1 (command done); bc_ack_out in 1 (slave ACK bit, 1 = NACK); bc_dout in 8 (received byte); bc_al in 1 (arbitration lost).

Function
REQ-008 SHALL decode registers: 0 CTRL rw {EN[7], IEN[6], 0[5:0]}; 1 SADR rw {addr[7:1], rw[0]}; 2 LEN rw (byte count 0-255); 3 DATA (write pushes TX FIFO, read pops RX FIFO).
REQ-009 SHALL decode registers: 4 CMD wo {GO[7]}; 5 STAT ro {BUSY, AL, NACK, IF, TXFULL, TXEMPTY, RXEMPTY, OVF}; 6 FLUSH wo {RXFL[1], TXFL[0]}; 7 reads 0.
REQ-010 SHALL assert wb_ack_o exactly one cycle after a cycle with wb_stb_i & wb_cyc_i & !wb_ack_o; wb_ack_o SHALL never be high on two consecutive cycles.
REQ-011 SHALL register wb_dat_o in the ack cycle; the DATA read SHALL return the RX FIFO head and pop it once, in the ack cycle.
REQ-012 SHALL drop a DATA write when TX FIFO is full and set OVF; a DATA read with RX FIFO empty SHALL return 0, not pop, and set OVF.
REQ-013 SHALL clear IF, AL, NACK and OVF on a STAT write with wb_dat_i[4]=1; flushing SHALL empty the selected FIFO in one cycle.
REQ-014 SHALL ignore GO when BUSY=1 or EN=0; an accepted GO SHALL set BUSY and clear AL and NACK.
REQ-015 SHALL use FSM states IDLE, ADR, DATA, STOP, DONE; BUSY = (state != IDLE).
REQ-016 ADR: drive bc_start=1, bc_write=1, bc_din=SADR, holding them until bc_cmd_ack; then go to STOP if bc_ack_out=1 (set NACK) or LEN=0, else to DATA.
REQ-017 DATA, write (rw=0): if TX FIFO is empty, issue nothing (stall); else drive bc_write=1 with bc_din=head, popping on bc_cmd_ack; NACK -> set NACK, go to STOP.
REQ-018 DATA, read (rw=1): if RX FIFO is full, stall; else drive bc_read=1 with bc_ack_in=1 only for the last byte, pushing bc_dout on bc_cmd_ack.
REQ-019 SHALL keep an 8-bit remaining counter loaded from LEN on GO, decremented per completed byte; at 0 go to STOP.
REQ-020 STOP: drive bc_stop=1 until bc_cmd_ack, then go to DONE.
REQ-021 DONE: set IF for one cycle, then go to IDLE.
REQ-022 SHALL, on bc_al=1 in any non-IDLE state: deassert all bc_* commands the next cycle, set AL and IF, go to IDLE, and issue no STOP.
REQ-023 SHALL give a same-cycle FIFO push and pop a correct level; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 SHALL apply a CPU flush of TX during DATA-write before a same-cycle pop.
REQ-025 SHALL register wb_inta_o = IEN & IF, one cycle late.
REQ-026 SHALL keep writes to CTRL, SADR and LEN during BUSY from affecting the burst in progress.

Reset
REQ-027 SHALL, on arst_i=0, asynchronously set: all registers 0; FIFOs empty; state IDLE; wb_ack_o, wb_inta_o, wb_dat_o and all bc_* outputs 0.
REQ-028 SHALL, when reset occurs mid-burst, drop the transfer with no STOP issued; STAT reads 0x06 after reset.

Verification
REQ-029 Write burst: EN=1, SADR=0xA0, LEN=3, push 11,22,33, GO -> bc_din sequence A0,11,22,33; then bc_stop; IF=1; STAT=0x16.
REQ-030 Read burst: SADR=0xA1, LEN=2, model returns 5A,C3 -> bc_ack_in 0 then 1; DATA reads 5A then C3; RXEMPTY=1.
REQ-031 Address NACK: bc_ack_out=1 on the address byte -> no DATA commands; STOP issued; STAT NACK=1, IF=1.
REQ-032 Arbitration loss during the second write byte -> commands drop the next cycle; no STOP; AL=1; wb_inta_o=1 with IEN=1.
REQ-033 FIFO boundaries: push FIFO_DEPTH+1 bytes -> TXFULL=1 and OVF=1 with DEPTH bytes stored; read burst LEN=DEPTH+2 with no CPU reads -> stalls at full, completes after reads.
REQ-034 Reset: assert arst_i mid-DATA -> all outputs 0 immediately; BUSY=0.
